// File: rtl/seg_scan_pkg.sv
// Shared constants and helpers for the two-digit segment scanner.
// Segment codes are common-anode (active-low): 8'hFF is all segments off.
package seg_scan_pkg;

    localparam logic [7:0] SEG_BLANK = 8'hFF;
    localparam logic [7:0] SEG_ZERO  = 8'hC0;

    localparam logic [1:0] DIG_OFF = 2'b11;
    localparam logic [1:0] DIG_LO  = 2'b10;
    localparam logic [1:0] DIG_HI  = 2'b01;

    typedef enum logic {
        SLOT_LO = 1'b0,
        SLOT_HI = 1'b1
    } slot_t;

    // Width of the in-slot cycle counter; never narrower than one bit.
    function automatic int cnt_width(input int div);
        return (div > 2) ? $clog2(div) : 1;
    endfunction

endpackage

// File: rtl/scan_slot_ctr.sv
// Slot timing for the scanner: counts DIV cycles per digit slot and
// alternates between the low and high digit slot.
module scan_slot_ctr
    import seg_scan_pkg::*;
#(
    parameter int DIV = 4,
    localparam int CW = cnt_width(DIV)
) (
    input  logic          ck,
    input  logic          rs,
    output logic [CW-1:0] cnt,
    output slot_t         slot,
    output logic          wrap,
    output logic          frame_end
);

    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    assign wrap      = (cnt == LAST);
    assign frame_end = wrap && (slot == SLOT_HI);

    // Advance the in-slot counter; on the last cycle of a slot wrap and swap digits.
    always_ff @(posedge ck or negedge rs) begin
        if (!rs) begin
            cnt  <= '0;
            slot <= SLOT_LO;
        end else if (wrap) begin
            cnt  <= '0;
            slot <= (slot == SLOT_LO) ? SLOT_HI : SLOT_LO;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/seg_scan_mux.sv
// Two-digit display scanner: snapshots both segment codes at every slot
// boundary, blanks the first BLANK cycles of each slot to stop ghosting,
// and drives one shared segment bus with active-low digit enables.
// Optional build macro SEG_SCAN_LZB_EN: suppress a leading '0' on the
// high digit (low digit and frame_tick are unaffected).
module seg_scan_mux
    import seg_scan_pkg::*;
#(
    parameter int DIV   = 4,
    parameter int BLANK = 1
) (
    input  logic       ck,
    input  logic       rs,
    input  logic [7:0] seg_lo,
    input  logic [7:0] seg_hi,
    output logic [7:0] seg_out,
    output logic [1:0] dig_en,
    output logic       frame_tick
);

    localparam int CW = cnt_width(DIV);

    logic [CW-1:0] cnt;
    slot_t         slot;
    logic          wrap;
    logic          frame_end;
    logic [7:0]    snap_lo;
    logic [7:0]    snap_hi;
    logic          in_blank;
    logic [7:0]    seg_nxt;
    logic [1:0]    dig_nxt;

    scan_slot_ctr #(.DIV(DIV)) u_ctr (
        .ck        (ck),
        .rs        (rs),
        .cnt       (cnt),
        .slot      (slot),
        .wrap      (wrap),
        .frame_end (frame_end)
    );

    generate
        if (BLANK == 0) begin : g_nogap
            assign in_blank = 1'b0;
        end else begin : g_gap
            localparam logic [CW-1:0] BLANK_C = CW'(BLANK);
            assign in_blank = (cnt < BLANK_C);
        end
    endgenerate

    // Select what the pins show next cycle from the current slot state and snapshots.
    always_comb begin
        seg_nxt = SEG_BLANK;
        dig_nxt = DIG_OFF;
        if (!in_blank) begin
            if (slot == SLOT_LO) begin
                seg_nxt = snap_lo;
                dig_nxt = DIG_LO;
            end else begin
`ifdef SEG_SCAN_LZB_EN
                if (snap_hi != SEG_ZERO) begin
                    seg_nxt = snap_hi;
                    dig_nxt = DIG_HI;
                end
`else
                seg_nxt = snap_hi;
                dig_nxt = DIG_HI;
`endif
            end
        end
    end

    // Capture inputs only at slot boundaries so a digit never tears, and register the pins.
    always_ff @(posedge ck or negedge rs) begin
        if (!rs) begin
            snap_lo    <= SEG_BLANK;
            snap_hi    <= SEG_BLANK;
            seg_out    <= SEG_BLANK;
            dig_en     <= DIG_OFF;
            frame_tick <= 1'b0;
        end else begin
            if (wrap) begin
                snap_lo <= seg_lo;
                snap_hi <= seg_hi;
            end
            seg_out    <= seg_nxt;
            dig_en     <= dig_nxt;
            frame_tick <= frame_end;
        end
    end

endmodule

// File: tb/tb_seg_scan_mux.sv
// Self-checking bench for seg_scan_mux: instance a (DIV=4, BLANK=1) and
// instance b (DIV=2, BLANK=0) share clock, reset and inputs. A frame-position
// reference model checks both every cycle; a vector table pins down the
// first frames of instance a exactly.
module tb_seg_scan_mux;

    logic       ck = 1'b0;
    logic       rs = 1'b1;
    logic [7:0] seg_lo = 8'hFF;
    logic [7:0] seg_hi = 8'hFF;

    logic [7:0] a_seg, b_seg;
    logic [1:0] a_dig, b_dig;
    logic       a_tick, b_tick;

    int checks   = 0;
    int failures = 0;

    seg_scan_mux #(.DIV(4), .BLANK(1)) dut_a (
        .ck(ck), .rs(rs), .seg_lo(seg_lo), .seg_hi(seg_hi),
        .seg_out(a_seg), .dig_en(a_dig), .frame_tick(a_tick)
    );

    seg_scan_mux #(.DIV(2), .BLANK(0)) dut_b (
        .ck(ck), .rs(rs), .seg_lo(seg_lo), .seg_hi(seg_hi),
        .seg_out(b_seg), .dig_en(b_dig), .frame_tick(b_tick)
    );

    always #5 ck = ~ck;

    // Reference model: position since reset decides slot and phase arithmetically.
    int         divs[2]   = '{4, 2};
    int         blanks[2] = '{1, 0};
    longint     pos[2];
    logic [7:0] shown_lo[2];
    logic [7:0] shown_hi[2];
    logic [7:0] exp_seg[2];
    logic [1:0] exp_dig[2];
    logic       exp_tick[2];

    // Predict the pins after each edge; a held reset forces the blank state.
    always @(posedge ck or negedge rs) begin
        if (!rs) begin
            for (int i = 0; i < 2; i++) begin
                pos[i] = 0; shown_lo[i] = 8'hFF; shown_hi[i] = 8'hFF;
                exp_seg[i] = 8'hFF; exp_dig[i] = 2'b11; exp_tick[i] = 1'b0;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                longint phase;
                longint half;
                phase = pos[i] % divs[i];
                half  = (pos[i] / divs[i]) % 2;
                exp_seg[i] = 8'hFF;
                exp_dig[i] = 2'b11;
                if (phase >= blanks[i]) begin
                    if (half == 0) begin
                        exp_seg[i] = shown_lo[i]; exp_dig[i] = 2'b10;
                    end else begin
                        exp_seg[i] = shown_hi[i]; exp_dig[i] = 2'b01;
`ifdef SEG_SCAN_LZB_EN
                        if (shown_hi[i] == 8'hC0) begin
                            exp_seg[i] = 8'hFF; exp_dig[i] = 2'b11;
                        end
`endif
                    end
                end
                exp_tick[i] = ((pos[i] % (2 * divs[i])) == (2 * divs[i] - 1));
                if (phase == divs[i] - 1) begin
                    shown_lo[i] = seg_lo;
                    shown_hi[i] = seg_hi;
                end
                pos[i] = pos[i] + 1;
            end
        end
    end

    typedef struct {
        logic [7:0] lo;
        logic [7:0] hi;
        logic [1:0] dig;
        logic [7:0] seg;
        logic       tick;
    } vec_t;

    vec_t tbl[24];

    function automatic vec_t mk(input logic [7:0] lo, input logic [7:0] hi,
                                input int kind, input logic [7:0] v, input logic tick);
        vec_t r;
        r.lo = lo; r.hi = hi; r.tick = tick;
        r.dig = 2'b11; r.seg = 8'hFF;
        if (kind == 1) begin
            r.dig = 2'b10; r.seg = v;
        end else if (kind == 2) begin
            r.dig = 2'b01; r.seg = v;
`ifdef SEG_SCAN_LZB_EN
            if (v == 8'hC0) begin
                r.dig = 2'b11; r.seg = 8'hFF;
            end
`endif
        end
        return r;
    endfunction

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("[TB] FAIL %s: got %h required %h at %0t", name, act, req, $time);
        end
    endtask

    task automatic applyStimulus(input logic [7:0] lo, input logic [7:0] hi);
        seg_lo = lo;
        seg_hi = hi;
    endtask

    task automatic checkOutput(input string tag);
        chk({tag, " a.seg"},  a_seg,         exp_seg[0]);
        chk({tag, " a.dig"},  {6'd0, a_dig}, {6'd0, exp_dig[0]});
        chk({tag, " a.tick"}, {7'd0, a_tick}, {7'd0, exp_tick[0]});
        chk({tag, " b.seg"},  b_seg,         exp_seg[1]);
        chk({tag, " b.dig"},  {6'd0, b_dig}, {6'd0, exp_dig[1]});
        chk({tag, " b.tick"}, {7'd0, b_tick}, {7'd0, exp_tick[1]});
        if (b_dig == 2'b00 || a_dig == 2'b00) begin
            failures++;
            $display("[TB] FAIL both_digits_on: a=%b b=%b required never 00", a_dig, b_dig);
        end
        checks++;
    endtask

    // Drive row inputs at a falling edge, let one rising edge pass, compare.
    task automatic runRows(input int first, input int last);
        for (int r = first; r <= last; r++) begin
            applyStimulus(tbl[r].lo, tbl[r].hi);
            @(negedge ck);
            chk($sformatf("row%0d seg", r), a_seg, tbl[r].seg);
            chk($sformatf("row%0d dig", r), {6'd0, a_dig}, {6'd0, tbl[r].dig});
            chk($sformatf("row%0d tick", r), {7'd0, a_tick}, {7'd0, tbl[r].tick});
            checkOutput($sformatf("row%0d model", r));
        end
    endtask

    initial begin
        int found;
        // Frame 0 shows reset snapshot on the low digit; seg_lo changes to A4
        // during the second F9 drive cycle and appears from frame 2.
        for (int n = 1; n <= 24; n++) begin
            int q, f, kind;
            logic [7:0] lo, v;
            q  = (n - 1) % 8;
            f  = (n - 1) / 8;
            lo = (n >= 12) ? 8'hA4 : 8'hF9;
            kind = (q == 0 || q == 4) ? 0 : (q < 4 ? 1 : 2);
            if (kind == 1) v = (f == 0) ? 8'hFF : ((f == 1) ? 8'hF9 : 8'hA4);
            else           v = 8'hC0;
            tbl[n - 1] = mk(lo, 8'hC0, kind, v, q == 7);
        end
        for (int i = 0; i < 2; i++) begin
            pos[i] = 0; shown_lo[i] = 8'hFF; shown_hi[i] = 8'hFF;
            exp_seg[i] = 8'hFF; exp_dig[i] = 2'b11; exp_tick[i] = 1'b0;
        end

        #1 rs = 1'b0;
        repeat (3) begin
            @(negedge ck);
            chk("reset a.seg", a_seg, 8'hFF);
            chk("reset a.dig", {6'd0, a_dig}, 8'h03);
            chk("reset a.tick", {7'd0, a_tick}, 8'h00);
            checkOutput("reset");
        end

        $display("[TB] releasing reset, first frames");
        rs = 1'b1;
        runRows(0, 23);

        // Async reset during a high-digit drive cycle, no clock edge needed.
        found = 0;
        for (int k = 0; k < 16 && found == 0; k++) begin
            @(negedge ck);
            if (a_dig == 2'b01) found = 1;
        end
        checks++;
        if (found == 0) begin
            failures++;
            $display("[TB] FAIL wait_hi_slot: got no 01 cycle required one within 16 cycles");
        end
        #1 rs = 1'b0;
        #1;
        chk("async a.seg", a_seg, 8'hFF);
        chk("async a.dig", {6'd0, a_dig}, 8'h03);
        chk("async a.tick", {7'd0, a_tick}, 8'h00);
        chk("async b.dig", {6'd0, b_dig}, 8'h03);
        repeat (2) begin
            @(negedge ck);
            checkOutput("held reset");
        end
        $display("[TB] restart after mid-frame reset");
        rs = 1'b1;
        runRows(0, 7);

        // Randomised input traffic against the model.
        for (int k = 0; k < 400; k++) begin
            if ($urandom_range(2) == 0) seg_lo = 8'($urandom);
            if ($urandom_range(2) == 0)
                seg_hi = ($urandom_range(3) == 0) ? 8'hC0 : 8'($urandom);
            @(negedge ck);
            checkOutput("random");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
